spi_frame_rx: RTL and testbench

Parametrised SPI slave receiver for the control/display path. It receives frames of N_WORDS words of WORD_W bits from the MCU. All SPI inputs are sampled in the clk domain, so there is no logic clocked by sclk. A frame is committed atomically to the output register only when the bit count is exact. A one-cycle valid pulse or error pulse is issued per frame, and a wrapping count of good frames is kept. It replaces the single-word, fixed-mode receiver that feeds frequency/config words to downstream synth logic.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_frame_rx_if.sv | 12 +
 rtl/sync_edge.sv | 42 ++++
 rtl/spi_frame_rx.sv | 169 ++++++++++++++++
 tb/tb_spi_frame_rx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame receiver.
//   state_e        : receiver FSM states
//   sample_on_rise : selects the rising or falling edge of sclk as the data-capture edge
//   cnt_width      : width of a counter that must hold values 0..total_bits
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  // Modes 0 and 3 capture on the rising edge; modes 1 and 2 capture on the falling edge.
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return (cpol ^ cpha) == 1'b0;
  endfunction

  function automatic int cnt_width(input int total_bits);
    return $clog2(total_bits + 1);
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// SPI bus bundle between an MCU (master) and the frame receiver (slave).
//   sclk : SPI clock, asynchronous to the receiver's system clock
//   sdi  : serial data, MSB first
//   cs   : chip select, active low
interface spi_frame_rx_if;
  logic sclk;
  logic sdi;
  logic cs;

  modport master (output sclk, output sdi, output cs);
  modport slave  (input  sclk, input  sdi, input  cs);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by one history flop for edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronised level
//   rise, fall : one-cycle strobes on synchronised transitions
// On reset every flop is loaded with RST_VAL, so no edge is reported until
// the pin differs from that idle level.
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver. All SPI inputs are oversampled in the clk domain
// (clk must be at least 4x sclk). A frame of N_WORDS x WORD_W bits is
// committed to data only when exactly TOTAL_BITS sample edges were seen while
// cs was low; otherwise the frame is dropped with a frame_err pulse.
//   clk, reset : system clock, synchronous active-high reset
//   spi        : SPI bus (sclk, sdi, cs), slave side
//   data       : last good frame, first-received bit in the MSB
//   data_valid : one-cycle pulse when data updates
//   frame_err  : one-cycle pulse when a frame is discarded
//   frame_cnt  : number of good frames, wraps 255 -> 0
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int N_WORDS     = 1,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  spi_frame_rx_if.slave               spi,
  output logic [WORD_W*N_WORDS-1:0]   data,
  output logic                        data_valid,
  output logic                        frame_err,
  output logic [7:0]                  frame_cnt
);

  localparam int TOTAL_BITS  = WORD_W * N_WORDS;
  localparam int CNT_W       = cnt_width(TOTAL_BITS);
  localparam int FLUSH_W     = $clog2(SYNC_STAGES + 1);
  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  localparam logic [CNT_W-1:0]   TOTAL_C   = CNT_W'(TOTAL_BITS);
  localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_STAGES);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;
  logic sample_edge;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi.sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(spi.cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .din(spi.sdi),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;
  logic [FLUSH_W-1:0]      flush_q, flush_d;
  logic [TOTAL_BITS-1:0]   shreg_q, shreg_d;
  logic [TOTAL_BITS-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    flush_d     = flush_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      WAIT_IDLE: begin
        // The synchroniser leaves reset showing cs high before any real pin
        // sample has reached its output; wait until it has been flushed so a
        // frame already running at reset release is never mistaken for idle.
        if (flush_q != FLUSH_MAX) begin
          flush_d = flush_q + FLUSH_W'(1);
        end else if (cs_level) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          // Outputs are registered here so they appear during the COMMIT cycle.
          state_d = COMMIT;
          if (cnt_q == TOTAL_C && !ovr_q) begin
            data_d      = shreg_q;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sample_edge) begin
          shreg_d = {shreg_q[TOTAL_BITS-2:0], sdi_level};
          if (cnt_q < TOTAL_C) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovr_d = 1'b1;
          end
        end
      end

      COMMIT: begin
        // A new frame may start right away; accept its cs fall here.
        if (cs_fall) begin
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      flush_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      flush_q     <= flush_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The shift register carries only data; whatever it holds is never
  // committed until a full frame has overwritten it.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;

  localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

  logic clk;
  logic reset;
  logic m_sclk [2];
  logic m_sdi  [2];
  logic m_cs   [2];

  spi_frame_rx_if if0 ();
  spi_frame_rx_if if1 ();

  assign if0.sclk = m_sclk[0];
  assign if0.sdi  = m_sdi[0];
  assign if0.cs   = m_cs[0];
  assign if1.sclk = m_sclk[1];
  assign if1.sdi  = m_sdi[1];
  assign if1.cs   = m_cs[1];

  logic [15:0] d0_data;
  logic        d0_valid, d0_err;
  logic [7:0]  d0_cnt;
  logic [23:0] d1_data;
  logic        d1_valid, d1_err;
  logic [7:0]  d1_cnt;

  // Instance 0: 16x1, mode 0. Instance 1: 8x3, CPOL=1, CPHA=1.
  spi_frame_rx u_dut0 (
    .clk(clk), .reset(reset), .spi(if0.slave),
    .data(d0_data), .data_valid(d0_valid), .frame_err(d0_err), .frame_cnt(d0_cnt)
  );

  spi_frame_rx #(.WORD_W(8), .N_WORDS(3), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .spi(if1.slave),
    .data(d1_data), .data_valid(d1_valid), .frame_err(d1_err), .frame_cnt(d1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitors (bench-side, unaffected by DUT reset).
  int vld0_n = 0, err0_n = 0, vld1_n = 0, err1_n = 0;
  int both_n = 0, wide_n = 0;
  logic pv0 = 1'b0, pe0 = 1'b0, pv1 = 1'b0, pe1 = 1'b0;

  always @(negedge clk) begin
    if (d0_valid) vld0_n <= vld0_n + 1;
    if (d0_err)   err0_n <= err0_n + 1;
    if (d1_valid) vld1_n <= vld1_n + 1;
    if (d1_err)   err1_n <= err1_n + 1;
    if ((d0_valid && d0_err) || (d1_valid && d1_err)) both_n <= both_n + 1;
    if ((d0_valid && pv0) || (d0_err && pe0) || (d1_valid && pv1) || (d1_err && pe1))
      wide_n <= wide_n + 1;
    pv0 <= d0_valid; pe0 <= d0_err; pv1 <= d1_valid; pe1 <= d1_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic cs_low(input int sel);
    @(posedge clk); #1;
    m_cs[sel] = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_high(input int sel);
    wait_cyc(HALF);
    @(posedge clk); #1;
    m_cs[sel] = 1'b1;
  endtask

  // Drive n bits MSB first. Data is set a half period before the leading edge
  // and held two cycles past the trailing edge, so either capture edge sees it stable.
  task automatic spi_bits(input int sel, input logic [31:0] bits, input int n);
    logic idle;
    idle = (sel == 0) ? 1'b0 : 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      m_sdi[sel] = bits[i];
      wait_cyc(HALF); #1;
      m_sclk[sel] = ~idle;
      wait_cyc(HALF); #1;
      m_sclk[sel] = idle;
      wait_cyc(2);
    end
  endtask

  task automatic frame(input int sel, input logic [31:0] bits, input int n);
    cs_low(sel);
    spi_bits(sel, bits, n);
    cs_high(sel);
    wait_cyc(10);
    @(negedge clk);
  endtask

  int v0, e0, v1, e1;

  initial begin
    reset = 1'b1;
    m_sclk[0] = 1'b0; m_sdi[0] = 1'b0; m_cs[0] = 1'b1;
    m_sclk[1] = 1'b1; m_sdi[1] = 1'b0; m_cs[1] = 1'b1;

    // Reset state
    wait_cyc(5);
    @(negedge clk);
    check("rst_data0",  {16'h0, d0_data}, 32'h0);
    check("rst_valid0", {31'h0, d0_valid}, 32'h0);
    check("rst_err0",   {31'h0, d0_err},   32'h0);
    check("rst_cnt0",   {24'h0, d0_cnt},   32'h0);
    check("rst_data1",  {8'h0, d1_data},   32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cyc(10);

    // Mode 0 single word with latency check
    cs_low(0);
    spi_bits(0, 32'hA53C, 16);
    cs_high(0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("lat_before", {31'h0, d0_valid}, 32'h0);
    @(posedge clk); @(negedge clk);
    check("lat_valid",  {31'h0, d0_valid}, 32'h1);
    check("lat_data",   {16'h0, d0_data},  32'hA53C);
    @(posedge clk); @(negedge clk);
    check("lat_after",  {31'h0, d0_valid}, 32'h0);
    wait_cyc(10); @(negedge clk);
    check("a53c_cnt",   {24'h0, d0_cnt}, 32'd1);
    check("a53c_vldn",  vld0_n, 32'd1);
    check("a53c_errn",  err0_n, 32'd0);

    // 3x8, CPOL=1 CPHA=1
    frame(1, 32'h123456, 24);
    check("m3_data",  {8'h0, d1_data}, 32'h123456);
    check("m3_cnt",   {24'h0, d1_cnt}, 32'd1);
    check("m3_vldn",  vld1_n, 32'd1);
    frame(1, 32'h5555, 15);
    check("m3_short_err",  err1_n, 32'd1);
    check("m3_short_data", {8'h0, d1_data}, 32'h123456);
    check("m3_short_cnt",  {24'h0, d1_cnt}, 32'd1);
    check("m3_short_vldn", vld1_n, 32'd1);

    // Long frame, then zero-bit glitch, then good frame
    frame(0, 32'h1ABCD, 17);
    cs_low(0);
    cs_high(0);
    wait_cyc(10); @(negedge clk);
    check("long_glitch_err", err0_n, 32'd2);
    check("long_glitch_data", {16'h0, d0_data}, 32'hA53C);
    check("long_glitch_cnt",  {24'h0, d0_cnt},  32'd1);
    frame(0, 32'h0001, 16);
    check("one_data", {16'h0, d0_data}, 32'h0001);
    check("one_cnt",  {24'h0, d0_cnt},  32'd2);

    // Back-to-back frames, cs high for two clk cycles between them
    v0 = vld0_n;
    cs_low(0);
    spi_bits(0, 32'h1111, 16);
    wait_cyc(HALF);
    @(posedge clk); #1; m_cs[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1; m_cs[0] = 1'b0;
    wait_cyc(HALF);
    spi_bits(0, 32'h2222, 16);
    cs_high(0);
    wait_cyc(10); @(negedge clk);
    check("b2b_vldn", vld0_n - v0, 32'd2);
    check("b2b_data", {16'h0, d0_data}, 32'h2222);
    check("b2b_cnt",  {24'h0, d0_cnt},  32'd4);
    check("b2b_errn", err0_n, 32'd2);

    // Reset in the middle of a frame; the remainder must be ignored
    v0 = vld0_n; e0 = err0_n; v1 = vld1_n; e1 = err1_n;
    cs_low(0);
    spi_bits(0, 32'hA5, 8);
    @(posedge clk); #1; reset = 1'b1;
    wait_cyc(4); @(negedge clk);
    check("midrst_data0", {16'h0, d0_data}, 32'h0);
    check("midrst_cnt0",  {24'h0, d0_cnt},  32'h0);
    check("midrst_data1", {8'h0, d1_data},  32'h0);
    @(posedge clk); #1; reset = 1'b0;
    spi_bits(0, 32'h5A, 8);
    cs_high(0);
    wait_cyc(10); @(negedge clk);
    check("midrst_vldn", vld0_n - v0, 32'd0);
    check("midrst_errn", err0_n - e0, 32'd0);
    frame(0, 32'hBEEF, 16);
    check("beef_data", {16'h0, d0_data}, 32'hBEEF);
    check("beef_cnt",  {24'h0, d0_cnt},  32'd1);
    check("beef_vldn", vld0_n - v0, 32'd1);
    check("dut1_quiet", (vld1_n - v1) + (err1_n - e1), 32'd0);

    // Counter wrap: 255 more good frames makes 256 since reset
    v0 = vld0_n;
    for (int i = 1; i <= 254; i++) begin
      frame(0, 32'(i), 16);
    end
    check("wrap_pre_cnt", {24'h0, d0_cnt}, 32'd255);
    frame(0, 32'hC0DE, 16);
    check("wrap_cnt",  {24'h0, d0_cnt},  32'd0);
    check("wrap_data", {16'h0, d0_data}, 32'hC0DE);
    check("wrap_vldn", vld0_n - v0, 32'd255);

    check("pulse_overlap", both_n, 32'd0);
    check("pulse_width",   wide_n, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
